// File: rtl/boot_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// boot_write_ctrl_pkg
// Shared constants for the boot record write controller: destination one-hot
// codes, FSM state encoding and the default image-buffer beat count.
// -----------------------------------------------------------------------------
package boot_write_ctrl_pkg;

    // One-hot destination strobe codes
    localparam logic [2:0] DST_IM = 3'b100;
    localparam logic [2:0] DST_DM = 3'b010;
    localparam logic [2:0] DST_IB = 3'b001;

    // FSM state encoding
    typedef logic [1:0] bw_state_t;
    localparam bw_state_t IDLE = 2'd0;
    localparam bw_state_t MEMW = 2'd1;
    localparam bw_state_t IBW  = 2'd2;
    localparam bw_state_t FIN  = 2'd3;

    // Default bus geometry
    localparam int IB_DW_DEF  = 128;
    localparam int BEAT_W_DEF = 32;
    localparam int IB_BEATS   = IB_DW_DEF / BEAT_W_DEF;

    // Width of a beat index; at least one bit even for a single-beat record
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/boot_beat_slicer.sv
// -----------------------------------------------------------------------------
// boot_beat_slicer
// Combinational selection of one BEAT_W slice of the latched record word and
// construction of the matching image-buffer beat address {addr, idx}.
//   data_i  : latched record data (IB_DW bits)
//   addr_i  : latched record address (AW bits)
//   idx_i   : current beat index, beat 0 is the least-significant slice
//   beat_o  : selected beat data
//   waddr_o : beat address {addr_i, idx_i}
// -----------------------------------------------------------------------------
module boot_beat_slicer
    import boot_write_ctrl_pkg::*;
#(
    parameter int IB_DW  = IB_DW_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int AW     = 16,
    parameter int IDX_W  = 2
) (
    input  logic [IB_DW-1:0]    data_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [BEAT_W-1:0]   beat_o,
    output logic [AW+IDX_W-1:0] waddr_o
);

    localparam int NBEATS = IB_DW / BEAT_W;

    // Explicit mux keeps the index compare at IDX_W bits
    always_comb begin
        beat_o = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (idx_i == IDX_W'(i)) begin
                beat_o = data_i[i*BEAT_W +: BEAT_W];
            end
        end
    end

    assign waddr_o = {addr_i, idx_i};

endmodule

// File: rtl/boot_write_ctrl.sv
// -----------------------------------------------------------------------------
// boot_write_ctrl
// Turns completed bootloader records into IM/DM single-cycle writes or a
// sequence of image-buffer beats under a ready handshake, and keeps record
// status (saturating count, sticky overrun and bad-destination flags).
//   clk, rst        : clock, synchronous active-high reset
//   rec_dst/addr/data : one-cycle record strobe (one-hot dst) with payload
//   bootloading     : bootloader busy, folded into cpu_hold
//   im_we, dm_we    : one-cycle write pulses, mem_waddr/mem_wdata payload
//   ib_we, ib_rdy   : beat request held until accepted, ib_waddr/ib_wdata
//   busy            : record in flight (includes the capture cycle)
//   rec_cnt         : records written, saturating
//   overrun, bad_dst: sticky status flags
//   cpu_hold        : bootloading | busy
// -----------------------------------------------------------------------------
module boot_write_ctrl
    import boot_write_ctrl_pkg::*;
#(
    parameter int IB_DW  = IB_DW_DEF,
    parameter int MEM_DW = 32,
    parameter int ADDRW  = 15,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int CNT_W  = 16,
    localparam int NBEATS = IB_DW / BEAT_W,
    localparam int IDX_W  = beat_idx_w(NBEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             rec_dst,
    input  logic [ADDRW:0]         rec_addr,
    input  logic [IB_DW-1:0]       rec_data,
    input  logic                   bootloading,
    output logic                   im_we,
    output logic                   dm_we,
    output logic [ADDRW:0]         mem_waddr,
    output logic [MEM_DW-1:0]      mem_wdata,
    output logic                   ib_we,
    input  logic                   ib_rdy,
    output logic [ADDRW+IDX_W:0]   ib_waddr,
    output logic [BEAT_W-1:0]      ib_wdata,
    output logic                   busy,
    output logic [CNT_W-1:0]       rec_cnt,
    output logic                   overrun,
    output logic                   bad_dst,
    output logic                   cpu_hold
);

    bw_state_t          state_q, state_d;
    logic [2:0]         dst_q, dst_d;
    logic [ADDRW:0]     addr_q, addr_d;
    logic [IB_DW-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovr_q, ovr_d;
    logic               bad_q, bad_d;

    logic strobe;
    logic legal;

    assign strobe = |rec_dst;
    assign legal  = (rec_dst == DST_IM) || (rec_dst == DST_DM) || (rec_dst == DST_IB);

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // Any strobe outside IDLE is dropped; a malformed strobe is flagged in any state
        ovr_d   = ovr_q | (strobe && (state_q != IDLE));
        bad_d   = bad_q | (strobe && !legal);

        case (state_q)
            IDLE: begin
                if (legal) begin
                    dst_d   = rec_dst;
                    addr_d  = rec_addr;
                    data_d  = rec_data;
                    idx_d   = '0;
                    state_d = (rec_dst == DST_IB) ? IBW : MEMW;
                end
            end
            MEMW: state_d = FIN;
            IBW: begin
                if (ib_rdy) begin
                    if (idx_q == IDX_W'(NBEATS - 1)) begin
                        idx_d   = '0;
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FIN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dst_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            bad_q   <= bad_d;
        end
    end

    boot_beat_slicer #(
        .IB_DW  (IB_DW),
        .BEAT_W (BEAT_W),
        .AW     (ADDRW + 1),
        .IDX_W  (IDX_W)
    ) u_slicer (
        .data_i  (data_q),
        .addr_i  (addr_q),
        .idx_i   (idx_q),
        .beat_o  (ib_wdata),
        .waddr_o (ib_waddr)
    );

    assign im_we     = (state_q == MEMW) && (dst_q == DST_IM);
    assign dm_we     = (state_q == MEMW) && (dst_q == DST_DM);
    assign ib_we     = (state_q == IBW);
    assign mem_waddr = addr_q;
    assign mem_wdata = data_q[IB_DW-1 -: MEM_DW];
    // Capture cycle already counts as busy so the CPU hold has no gap
    assign busy      = (state_q != IDLE) || legal;
    assign cpu_hold  = bootloading | busy;
    assign rec_cnt   = cnt_q;
    assign overrun   = ovr_q;
    assign bad_dst   = bad_q;

endmodule
